// File: rtl/count_ctrl.sv
// Button-to-counter command sequencer: one pulse per press, optional hold-to-repeat.
// Define COUNT_CTRL_REPEAT_EN to build the HOLD/REPEAT auto-repeat path and its timer.
module count_ctrl #(
  parameter logic [23:0] DELAY = 24'd10_000_000,
  parameter logic [23:0] RATE  = 24'd2_500_000,
  parameter bit          WRAP  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       clr,
  input  logic [3:0] count,
  output logic       inc,
  output logic       dec,
  output logic       zero,
  output logic       busy
);

  localparam int unsigned TIMER_W = 24;
  localparam logic [3:0]  COUNT_MAX = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FIRE    = 3'd1,
`ifdef COUNT_CTRL_REPEAT_EN
    S_HOLD    = 3'd2,
    S_REPEAT  = 3'd3,
`endif
    S_RELEASE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_UP   = 2'd1,
    OWN_DOWN = 2'd2,
    OWN_CLR  = 2'd3
  } owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   inc_q, inc_d;
  logic   dec_q, dec_d;
  logic   zero_q, zero_d;
  logic   busy_q, busy_d;
  logic   fire_c;

`ifdef COUNT_CTRL_REPEAT_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               owner_lvl_c;

  // Live level of whichever button currently owns the sequence.
  always_comb begin
    owner_lvl_c = 1'b0;
    case (owner_q)
      OWN_UP:   owner_lvl_c = up;
      OWN_DOWN: owner_lvl_c = down;
      OWN_CLR:  owner_lvl_c = clr;
      default:  owner_lvl_c = 1'b0;
    endcase
  end
`else
  logic unused_cfg_c;
  assign unused_cfg_c = ^{DELAY, RATE};
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef COUNT_CTRL_REPEAT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
`ifdef COUNT_CTRL_REPEAT_EN
      timer_q <= timer_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    fire_c  = 1'b0;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    zero_d  = 1'b0;
`ifdef COUNT_CTRL_REPEAT_EN
    timer_d = timer_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (clr) begin
          owner_d = OWN_CLR;
          state_d = S_FIRE;
        end else if (up) begin
          owner_d = OWN_UP;
          state_d = S_FIRE;
        end else if (down) begin
          owner_d = OWN_DOWN;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        fire_c = 1'b1;
`ifdef COUNT_CTRL_REPEAT_EN
        if (owner_q == OWN_CLR) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_HOLD;
          timer_d = '0;
        end
`else
        state_d = S_RELEASE;
`endif
      end
`ifdef COUNT_CTRL_REPEAT_EN
      S_HOLD: begin
        if (!owner_lvl_c) begin
          state_d = S_RELEASE;
        end else if (timer_q == DELAY - TIMER_W'(1)) begin
          fire_c  = 1'b1;
          state_d = S_REPEAT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_REPEAT: begin
        if (!owner_lvl_c) begin
          state_d = S_RELEASE;
        end else if (timer_q == RATE - TIMER_W'(1)) begin
          fire_c  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
`endif
      S_RELEASE: begin
        if (!(up || down || clr)) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // Saturating mode swallows the edge pulse but the sequence keeps its timing.
    if (fire_c) begin
      case (owner_q)
        OWN_UP:   inc_d  = WRAP || (count != COUNT_MAX);
        OWN_DOWN: dec_d  = WRAP || (count != 4'd0);
        OWN_CLR:  zero_d = 1'b1;
        default:  ;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign inc  = inc_q;
  assign dec  = dec_q;
  assign zero = zero_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Randomised bench for count_ctrl: saturating and wrapping instances against one press-age model.
module tb_count_ctrl;

  localparam logic [23:0] T_DELAY = 24'd8;
  localparam logic [23:0] T_RATE  = 24'd4;
  localparam int DLY = 8;
  localparam int RT  = 4;
`ifdef COUNT_CTRL_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       up = 1'b0, down = 1'b0, clr = 1'b0;
  logic [3:0] count = 4'd0;
  logic       inc0, dec0, zero0, busy0;
  logic       inc1, dec1, zero1, busy1;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  count_ctrl #(.DELAY(T_DELAY), .RATE(T_RATE), .WRAP(1'b0)) dut_sat (
    .clock(clock), .reset(reset), .up(up), .down(down), .clr(clr), .count(count),
    .inc(inc0), .dec(dec0), .zero(zero0), .busy(busy0)
  );

  count_ctrl #(.DELAY(T_DELAY), .RATE(T_RATE), .WRAP(1'b1)) dut_wrap (
    .clock(clock), .reset(reset), .up(up), .down(down), .clr(clr), .count(count),
    .inc(inc1), .dec(dec1), .zero(zero1), .busy(busy1)
  );

  // Model: phase 0 idle, 1 press active, 2 waiting for all buttons low.
  // Pulses fall at press ages 1, DELAY+1, DELAY+1+k*RATE while the owner stays held.
  int   m_phase = 0;
  int   m_owner = 0;
  int   m_age = 0;
  bit   chk_en = 1'b0;
  logic e_inc0, e_dec0, e_inc1, e_dec1, e_zero, e_busy;

  always @(posedge clock) begin : model
    bit fire;
    bit lvl;
    fire = 1'b0;
    if (!reset) begin
      m_phase = 0;
      m_owner = 0;
      m_age   = 0;
      chk_en  = 1'b1;
    end else begin
      case (m_phase)
        0: if (clr || up || down) begin
          m_owner = clr ? 3 : (up ? 1 : 2);
          m_phase = 1;
          m_age   = 0;
        end
        1: begin
          m_age = m_age + 1;
          lvl = (m_owner == 1) ? up : ((m_owner == 2) ? down : clr);
          if (m_age == 1) begin
            fire = 1'b1;
            if (m_owner == 3 || !REP) m_phase = 2;
          end else if (!lvl) begin
            m_phase = 2;
          end else if ((m_age - 1) >= DLY && ((m_age - 1 - DLY) % RT) == 0) begin
            fire = 1'b1;
          end
        end
        default: if (!(up || down || clr)) m_phase = 0;
      endcase
    end
    e_inc1 = fire && (m_owner == 1);
    e_dec1 = fire && (m_owner == 2);
    e_zero = fire && (m_owner == 3);
    e_inc0 = e_inc1 && (count != 4'd15);
    e_dec0 = e_dec1 && (count != 4'd0);
    e_busy = (m_phase != 0);
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare both instances to the model.
  task automatic step();
    @(negedge clock);
    if (chk_en) begin
      chk("inc_sat",   inc0,  e_inc0);
      chk("dec_sat",   dec0,  e_dec0);
      chk("zero_sat",  zero0, e_zero);
      chk("busy_sat",  busy0, e_busy);
      chk("inc_wrap",  inc1,  e_inc1);
      chk("dec_wrap",  dec1,  e_dec1);
      chk("zero_wrap", zero1, e_zero);
      chk("busy_wrap", busy1, e_busy);
    end
  endtask

  // Press a button set for `hold` cycles; return bitmasks of pulse cycles relative to press.
  task automatic scen(input bit u, input bit d, input bit c, input int hold,
                      input logic [3:0] cnt, input int total,
                      output int mi0, output int mi1, output int md0, output int md1,
                      output int mz, output int last_busy);
    up = 1'b0; down = 1'b0; clr = 1'b0; count = cnt;
    repeat (3) step();
    up = u; down = d; clr = c;
    mi0 = 0; mi1 = 0; md0 = 0; md1 = 0; mz = 0; last_busy = -1;
    for (int i = 1; i <= total; i++) begin
      step();
      if (inc0)  mi0 |= (1 << i);
      if (inc1)  mi1 |= (1 << i);
      if (dec0)  md0 |= (1 << i);
      if (dec1)  md1 |= (1 << i);
      if (zero0) mz  |= (1 << i);
      if (busy0) last_busy = i;
      if (i == hold) begin
        up = 1'b0; down = 1'b0; clr = 1'b0;
      end
    end
  endtask

  initial begin : stim
    int mi0, mi1, md0, md1, mz, lb;
    int rep_mask;
    rep_mask = REP ? 32'h0004_4404 : 32'h0000_0004;

    // Reset held low with up pressed, then released with up still high.
    reset = 1'b0; up = 1'b1; count = 4'd5;
    step();
    step();
    chk("rst_inc",  inc0,  1'b0);
    chk("rst_dec",  dec0,  1'b0);
    chk("rst_zero", zero0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    reset = 1'b1;
    mi0 = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (inc0) mi0 |= (1 << i);
      if (i == 3) up = 1'b0;
    end
    chk_int("post_reset_inc", mi0, 32'h4);

    scen(1'b1, 1'b0, 1'b0, 3, 4'd5, 10, mi0, mi1, md0, md1, mz, lb);
    chk_int("short_up_inc", mi0, 32'h4);
    chk_int("short_up_busy_end", lb, REP ? 4 : 3);

    scen(1'b0, 1'b1, 1'b0, 20, 4'd9, 26, mi0, mi1, md0, md1, mz, lb);
    chk_int("held_down_dec_sat", md0, rep_mask);
    chk_int("held_down_dec_wrap", md1, rep_mask);
    chk_int("held_down_busy_end", lb, REP ? 21 : 20);

    scen(1'b1, 1'b1, 1'b1, 6, 4'd5, 12, mi0, mi1, md0, md1, mz, lb);
    chk_int("all3_zero", mz, 32'h4);
    chk_int("all3_incdec", mi0 | mi1 | md0 | md1, 0);
    chk_int("all3_busy_end", lb, 6);

    scen(1'b1, 1'b0, 1'b0, 20, 4'd15, 26, mi0, mi1, md0, md1, mz, lb);
    chk_int("top_inc_sat", mi0, 0);
    chk_int("top_inc_wrap", mi1, rep_mask);

    scen(1'b0, 1'b1, 1'b0, 12, 4'd0, 16, mi0, mi1, md0, md1, mz, lb);
    chk_int("bottom_dec_sat", md0, 0);
    chk_int("bottom_dec_wrap", md1, REP ? 32'h404 : 32'h4);

    // Randomised presses, count changes, glitches on other buttons and mid-press resets.
    for (int s = 0; s < 150; s++) begin
      int hold;
      int r;
      up   = ($urandom % 5) < 2;
      down = ($urandom % 5) < 2;
      clr  = ($urandom % 6) == 0;
      r = int'($urandom % 4);
      if (r == 0)      count = 4'd0;
      else if (r == 1) count = 4'd15;
      else             count = 4'($urandom);
      hold = int'($urandom_range(1, 30));
      for (int i = 0; i < hold; i++) begin
        reset = ($urandom % 40) != 0;
        if ($urandom % 8 == 0) count = 4'($urandom);
        if ($urandom % 16 == 0) begin
          r = int'($urandom % 3);
          if (r == 0)      up   = ~up;
          else if (r == 1) down = ~down;
          else             clr  = ~clr;
        end
        step();
      end
      reset = 1'b1;
      up = 1'b0; down = 1'b0; clr = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 SHALL have parameter DELAY, default 24'd10_000_000, giving hold cycles before auto-repeat starts (minimum 2).
REQ-002 SHALL have parameter RATE, default 24'd2_500_000, giving cycles between auto-repeat pulses (minimum 2).
REQ-003 SHALL have parameter WRAP, default 1'b0: 0 = saturate at 0/15, 1 = wrap modulo 16.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clock).
REQ-006 SHALL have port up  input  1  debounced count-up button level.
REQ-007 SHALL have port down  input  1  debounced count-down button level.
REQ-008 SHALL have port clr  input  1  debounced clear button level.
REQ-009 SHALL have port count  input  4  current value of the controlled counter.
REQ-010 SHALL have port inc  output  1  one-cycle increment command to the counter.
REQ-011 SHALL have port dec  output  1  one-cycle decrement command to the counter.
REQ-012 SHALL have port zero  output  1  one-cycle clear command to the counter.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, FIRE, HOLD, REPEAT, RELEASE; all outputs registered.
REQ-015 IDLE: on a cycle with any button high, SHALL latch one owner by priority clr > up > down and enter FIRE; lower-priority buttons that are high in the same cycle are ignored.
REQ-016 FIRE: SHALL assert exactly one command pulse for the owner in the cycle after the owner is latched (latency 1). Next state: clr owner -> RELEASE; otherwise -> HOLD with the timer cleared.
REQ-017 HOLD: timer SHALL increment each cycle while the owner stays high; on reaching DELAY-1 -> REPEAT with the timer cleared and one command pulse.
REQ-018 REPEAT: SHALL issue one command pulse every RATE cycles while the owner stays high.
REQ-019 In HOLD or REPEAT, owner low -> RELEASE with no pulse; any other button going high is ignored.
REQ-020 RELEASE: SHALL stay until up, down and clr are all low for one cycle, then -> IDLE.
REQ-021 At most one of inc, dec, zero SHALL be high in any cycle.
REQ-022 WRAP=0: SHALL suppress inc when count==15 and dec when count==0; the state and timer advance as if the pulse had been issued.
REQ-023 WRAP=1: inc and dec SHALL never be suppressed (the counter wraps 15->0 and 0->15).
REQ-024 The timer SHALL be 24 bits wide and SHALL never exceed max(DELAY, RATE)-1.
REQ-025 busy SHALL be high in FIRE, HOLD, REPEAT and RELEASE.

Reset
REQ-026 reset==0 at a rising edge SHALL force IDLE, clear timer and owner, and drive inc=dec=zero=busy=0 in the next cycle.
REQ-027 Reset asserted mid-HOLD or mid-REPEAT SHALL abort with no further pulse.
REQ-028 After reset releases with a button still high, SHALL treat it as a new press (IDLE -> FIRE).

Configuration
REQ-029 Macro COUNT_CTRL_REPEAT_EN defined: HOLD and REPEAT SHALL be built and behave per REQ-017..REQ-019.
REQ-030 Macro COUNT_CTRL_REPEAT_EN undefined: HOLD, REPEAT and the timer SHALL be omitted; FIRE always -> RELEASE, giving one pulse per press; DELAY and RATE are ignored.

Verification (DELAY=8, RATE=4, macro defined unless noted)
REQ-031 reset low 2 cycles with up=1 -> inc=dec=zero=busy=0; after release, one inc pulse 2 cycles later.
REQ-032 up high 3 cycles, count=5 -> exactly one inc; busy high until 1 cycle after up falls.
REQ-033 down held 20 cycles, count=9 -> dec pulses at cycles 2, 10, 14, 18 after press.
REQ-034 up+down+clr rise together -> single zero pulse, no inc/dec; RELEASE holds until all three are low.
REQ-035 WRAP=0, count=15, up held 20 cycles -> no inc pulses; WRAP=1 -> inc pulses at cycles 2, 10, 14, 18.
REQ-036 Macro undefined, up held 20 cycles -> exactly one inc, at cycle 2.
